eth_rx_fcs_check: RTL and testbench



---
 rtl/eth_pkg.sv | 39 +++
 rtl/crc32_byte_engine.sv | 44 ++++
 rtl/eth_rx_fcs_check.sv | 217 +++++++++++++++++++++
 tb/tb_eth_rx_fcs_check.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - shared stream type, CRC-32 constants and byte-wide CRC step
// Contents:
//   stream_t    byte stream beat (startofpacket, endofpacket, valid, data, error)
//   CRC32_POLY  Ethernet generator polynomial, MSB-first notation
//   CRC32_INIT  CRC register seed
//   FCS_BYTES   trailing FCS length in bytes
//   BUF_DEPTH   delay-line depth needed to hold back the FCS plus one payload byte
//   crc32_byte  next CRC register value after absorbing one byte, LSB first
package eth_pkg;

   typedef struct packed {
      logic       startofpacket;
      logic       endofpacket;
      logic       valid;
      logic [7:0] data;
      logic       error;
   } stream_t;

   localparam logic [31:0] CRC32_POLY = 32'h04C11DB7;
   localparam logic [31:0] CRC32_INIT = 32'hFFFFFFFF;
   localparam int          FCS_BYTES  = 4;
   localparam int          BUF_DEPTH  = FCS_BYTES + 1;

   // Register kept MSB-first while the wire order is LSB first, so the feedback
   // taps bit 31 against data bit 0, then bit 1, and so on.
   function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
      logic [31:0] c;
      c = crc;
      for (int i = 0; i < 8; i++) begin
         if (c[31] ^ data[i]) begin
            c = {c[30:0], 1'b0} ^ CRC32_POLY;
         end else begin
            c = {c[30:0], 1'b0};
         end
      end
      return c;
   endfunction

endpackage

// File: rtl/crc32_byte_engine.sv
// rtl/crc32_byte_engine.sv - registered byte-per-cycle CRC-32 accumulator
// Ports:
//   clk_i   clock
//   rst_i   asynchronous active-high reset, loads CRC32_INIT
//   init_i  restart from CRC32_INIT; with en_i the byte is absorbed into the fresh seed
//   en_i    absorb data_i this cycle
//   data_i  byte to absorb
//   crc_o   current CRC register, MSB-first notation, no final XOR
module crc32_byte_engine
   import eth_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        init_i,
   input  logic        en_i,
   input  logic [7:0]  data_i,
   output logic [31:0] crc_o
);

   logic [31:0] crc_q;
   logic [31:0] crc_d;
   logic [31:0] seed;

   always_comb begin
      seed  = init_i ? CRC32_INIT : crc_q;
      crc_d = crc_q;
      if (en_i) begin
         crc_d = crc32_byte(seed, data_i);
      end else if (init_i) begin
         crc_d = CRC32_INIT;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         crc_q <= CRC32_INIT;
      end else begin
         crc_q <= crc_d;
      end
   end

   assign crc_o = crc_q;

endmodule

// File: rtl/eth_rx_fcs_check.sv
// rtl/eth_rx_fcs_check.sv - receive FCS checker: verifies CRC-32 residue, strips FCS, counts frames
// Ports:
//   mac_clk, mac_rst       clock, asynchronous active-high reset
//   in_*                   receiver byte stream, destination MAC first, FCS last
//   out_*                  same frame with the 4 FCS bytes removed; out_error on the eop beat marks a bad frame
//   cnt_good               good frames emitted
//   cnt_fcs_err            frames whose CRC residue did not match
//   cnt_len_err            frames shorter than P_MIN_BYTES, dropped runts included
//   cnt_abort              frames cut short by a new startofpacket
//   All counters saturate at all-ones.
module eth_rx_fcs_check
   import eth_pkg::*;
#(
   parameter logic [31:0] P_RESIDUE   = 32'hC704DD7B,
   parameter int          P_MIN_BYTES = 64,
   parameter int          P_CNT_W     = 16
) (
   input  logic               mac_clk,
   input  logic               mac_rst,
   input  logic               in_startofpacket,
   input  logic               in_endofpacket,
   input  logic               in_valid,
   input  logic [7:0]         in_data,
   input  logic               in_error,
   output logic               out_startofpacket,
   output logic               out_endofpacket,
   output logic               out_valid,
   output logic [7:0]         out_data,
   output logic               out_error,
   output logic [P_CNT_W-1:0] cnt_good,
   output logic [P_CNT_W-1:0] cnt_fcs_err,
   output logic [P_CNT_W-1:0] cnt_len_err,
   output logic [P_CNT_W-1:0] cnt_abort
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FILL  = 2'd1;
   localparam logic [1:0] ST_PASS  = 2'd2;
   localparam logic [1:0] ST_FLUSH = 2'd3;

   localparam logic [2:0]         BUF_FULL = 3'(BUF_DEPTH);
   localparam logic [10:0]        LEN_MAX  = 11'h7FF;
   localparam logic [10:0]        LEN_MIN  = 11'(P_MIN_BYTES);
   localparam logic [P_CNT_W-1:0] CNT_ONE  = {{(P_CNT_W-1){1'b0}}, 1'b1};

   function automatic logic [P_CNT_W-1:0] sat_inc(input logic [P_CNT_W-1:0] v);
      return (&v) ? v : v + CNT_ONE;
   endfunction

   stream_t in_s;
   stream_t out_q, out_d;

   logic [1:0]                 state_q, state_d;
   logic [2:0]                 count_q, count_d;
   // Entry 0 is the newest byte; entry BUF_DEPTH-1 is the oldest and next to leave.
   logic [BUF_DEPTH-1:0][7:0]  buf_data_q, buf_data_d;
   logic [BUF_DEPTH-1:0]       buf_sop_q, buf_sop_d;
   logic [10:0]                len_q, len_d;
   logic                       sticky_q, sticky_d;
   logic [P_CNT_W-1:0]         good_q, good_d;
   logic [P_CNT_W-1:0]         fcs_q, fcs_d;
   logic [P_CNT_W-1:0]         lenerr_q, lenerr_d;
   logic [P_CNT_W-1:0]         abort_q, abort_d;

   logic        do_push;
   logic        do_restart;
   logic [31:0] crc;
   logic        len_short;
   logic        crc_bad;

   assign in_s = '{startofpacket: in_startofpacket, endofpacket: in_endofpacket,
                   valid: in_valid, data: in_data, error: in_error};

   crc32_byte_engine u_crc (
      .clk_i  (mac_clk),
      .rst_i  (mac_rst),
      .init_i (do_restart),
      .en_i   (do_push | do_restart),
      .data_i (in_s.data),
      .crc_o  (crc)
   );

   assign len_short = (len_q < LEN_MIN);
   assign crc_bad   = (crc != P_RESIDUE);

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      buf_data_d = buf_data_q;
      buf_sop_d  = buf_sop_q;
      len_d      = len_q;
      sticky_d   = sticky_q;
      good_d     = good_q;
      fcs_d      = fcs_q;
      lenerr_d   = lenerr_q;
      abort_d    = abort_q;
      out_d      = '0;
      do_push    = 1'b0;
      do_restart = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (in_s.valid && in_s.startofpacket) begin
               do_restart = 1'b1;
            end
         end

         ST_FILL, ST_PASS: begin
            if (in_s.valid) begin
               if (in_s.startofpacket) begin
                  // Truncated frame: once bytes have left, the downstream needs a closing eop.
                  do_restart = 1'b1;
                  if (state_q == ST_PASS) begin
                     out_d = '{startofpacket: buf_sop_q[BUF_DEPTH-1], endofpacket: 1'b1, valid: 1'b1,
                               data: buf_data_q[BUF_DEPTH-1], error: 1'b1};
                     abort_d = sat_inc(abort_q);
                  end
               end else if (in_s.endofpacket && (count_q + 3'd1 < BUF_FULL)) begin
                  // Too short to hold even one payload byte ahead of the FCS.
                  count_d    = 3'd0;
                  buf_data_d = '0;
                  buf_sop_d  = '0;
                  lenerr_d   = sat_inc(lenerr_q);
                  state_d    = ST_IDLE;
               end else begin
                  do_push = 1'b1;
                  if (state_q == ST_PASS) begin
                     out_d = '{startofpacket: buf_sop_q[BUF_DEPTH-1], endofpacket: 1'b0, valid: 1'b1,
                               data: buf_data_q[BUF_DEPTH-1], error: 1'b0};
                  end
                  if (in_s.endofpacket) begin
                     state_d = ST_FLUSH;
                  end else if (count_q + 3'd1 >= BUF_FULL) begin
                     state_d = ST_PASS;
                  end
               end
            end
         end

         ST_FLUSH: begin
            // Buffer now holds the last payload byte (oldest) followed by the 4 FCS bytes.
            out_d = '{startofpacket: buf_sop_q[BUF_DEPTH-1], endofpacket: 1'b1, valid: 1'b1,
                      data: buf_data_q[BUF_DEPTH-1], error: crc_bad | len_short | sticky_q};
            if (len_short) begin
               lenerr_d = sat_inc(lenerr_q);
            end else if (crc_bad) begin
               fcs_d = sat_inc(fcs_q);
            end else begin
               good_d = sat_inc(good_q);
            end
            count_d    = 3'd0;
            buf_data_d = '0;
            buf_sop_d  = '0;
            state_d    = ST_IDLE;
            if (in_s.valid && in_s.startofpacket) begin
               do_restart = 1'b1;
            end
         end

         default: state_d = ST_IDLE;
      endcase

      if (do_restart) begin
         buf_data_d = {{((BUF_DEPTH-1)*8){1'b0}}, in_s.data};
         buf_sop_d  = {{(BUF_DEPTH-1){1'b0}}, 1'b1};
         count_d    = 3'd1;
         len_d      = 11'd1;
         sticky_d   = in_s.error;
         state_d    = ST_FILL;
      end else if (do_push) begin
         buf_data_d = {buf_data_q[BUF_DEPTH-2:0], in_s.data};
         buf_sop_d  = {buf_sop_q[BUF_DEPTH-2:0], 1'b0};
         count_d    = (count_q == BUF_FULL) ? BUF_FULL : count_q + 3'd1;
         len_d      = (len_q == LEN_MAX) ? LEN_MAX : len_q + 11'd1;
         sticky_d   = sticky_q | in_s.error;
      end
   end

   always_ff @(posedge mac_clk or posedge mac_rst) begin
      if (mac_rst) begin
         state_q    <= ST_IDLE;
         count_q    <= 3'd0;
         buf_data_q <= '0;
         buf_sop_q  <= '0;
         len_q      <= 11'd0;
         sticky_q   <= 1'b0;
         good_q     <= '0;
         fcs_q      <= '0;
         lenerr_q   <= '0;
         abort_q    <= '0;
         out_q      <= '0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         buf_data_q <= buf_data_d;
         buf_sop_q  <= buf_sop_d;
         len_q      <= len_d;
         sticky_q   <= sticky_d;
         good_q     <= good_d;
         fcs_q      <= fcs_d;
         lenerr_q   <= lenerr_d;
         abort_q    <= abort_d;
         out_q      <= out_d;
      end
   end

   assign out_startofpacket = out_q.startofpacket;
   assign out_endofpacket   = out_q.endofpacket;
   assign out_valid         = out_q.valid;
   assign out_data          = out_q.data;
   assign out_error         = out_q.error;
   assign cnt_good          = good_q;
   assign cnt_fcs_err       = fcs_q;
   assign cnt_len_err       = lenerr_q;
   assign cnt_abort         = abort_q;

endmodule

// File: tb/tb_eth_rx_fcs_check.sv
// tb/tb_eth_rx_fcs_check.sv - directed self-checking bench for eth_rx_fcs_check
module tb_eth_rx_fcs_check;

   logic        mac_clk = 1'b0;
   logic        mac_rst = 1'b1;
   logic        in_startofpacket, in_endofpacket, in_valid, in_error;
   logic [7:0]  in_data;
   logic        out_startofpacket, out_endofpacket, out_valid, out_error;
   logic [7:0]  out_data;
   logic [15:0] cnt_good, cnt_fcs_err, cnt_len_err, cnt_abort;

   eth_rx_fcs_check dut (
      .mac_clk           (mac_clk),
      .mac_rst           (mac_rst),
      .in_startofpacket  (in_startofpacket),
      .in_endofpacket    (in_endofpacket),
      .in_valid          (in_valid),
      .in_data           (in_data),
      .in_error          (in_error),
      .out_startofpacket (out_startofpacket),
      .out_endofpacket   (out_endofpacket),
      .out_valid         (out_valid),
      .out_data          (out_data),
      .out_error         (out_error),
      .cnt_good          (cnt_good),
      .cnt_fcs_err       (cnt_fcs_err),
      .cnt_len_err       (cnt_len_err),
      .cnt_abort         (cnt_abort)
   );

   always #5 mac_clk = ~mac_clk;

   int cyc = 0;
   always @(posedge mac_clk) cyc <= cyc + 1;

   typedef struct {
      logic [7:0] d;
      logic       sop;
      logic       eop;
      logic       err;
      int         cyc;
   } beat_t;

   beat_t      rx[$];
   beat_t      mon_b;
   logic [7:0] tx[$];
   int         last_eop_cyc = 0;
   int         checks = 0;
   int         errors = 0;
   int         exp_good = 0, exp_fcs = 0, exp_len = 0, exp_abort = 0;

   always @(posedge mac_clk) begin
      #1;
      if (out_valid === 1'b1) begin
         mon_b.d   = out_data;
         mon_b.sop = out_startofpacket;
         mon_b.eop = out_endofpacket;
         mon_b.err = out_error;
         mon_b.cyc = cyc;
         rx.push_back(mon_b);
      end
   end

   // Payload base+i for i<n, then FCS from the reflected (LSB-first) CRC-32, sent LSB first.
   task automatic make_frame(input int n, input int base);
      logic [31:0] r;
      tx.delete();
      for (int i = 0; i < n; i++) tx.push_back(8'(base + i));
      r = 32'hFFFFFFFF;
      foreach (tx[i]) begin
         r = r ^ {24'h0, tx[i]};
         repeat (8) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      end
      r = ~r;
      tx.push_back(r[7:0]);
      tx.push_back(r[15:8]);
      tx.push_back(r[23:16]);
      tx.push_back(r[31:24]);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge mac_clk);
         in_valid = 1'b0; in_startofpacket = 1'b0; in_endofpacket = 1'b0;
         in_error = 1'b0; in_data = 8'h00;
      end
   endtask

   task automatic send_tx(input int err_idx, input int gap_every, input int gap_len, input bit with_eop);
      for (int i = 0; i < tx.size(); i++) begin
         if (gap_every > 0 && i > 0 && (i % gap_every) == 0) idle(gap_len);
         @(negedge mac_clk);
         in_valid         = 1'b1;
         in_data          = tx[i];
         in_startofpacket = (i == 0);
         in_endofpacket   = with_eop && (i == tx.size() - 1);
         in_error         = (i == err_idx);
         if (with_eop && i == tx.size() - 1) last_eop_cyc = cyc;
      end
   endtask

   task automatic test_reset();
      in_valid = 1'b0; in_startofpacket = 1'b0; in_endofpacket = 1'b0;
      in_error = 1'b0; in_data = 8'h00;
      mac_rst = 1'b1;
      idle(3);
      checks++;
      if ({out_valid, out_startofpacket, out_endofpacket, out_data, out_error} !== 12'h0) begin
         errors++;
         $display("FAIL reset_outputs: got v=%b sop=%b eop=%b d=%h err=%b expected all 0",
                  out_valid, out_startofpacket, out_endofpacket, out_data, out_error);
      end
      checks++;
      if ({cnt_good, cnt_fcs_err, cnt_len_err, cnt_abort} !== 64'h0) begin
         errors++;
         $display("FAIL reset_counters: got %h %h %h %h expected 0 0 0 0", cnt_good, cnt_fcs_err, cnt_len_err, cnt_abort);
      end
      mac_rst = 1'b0;
      idle(2);
      // Bytes without startofpacket in IDLE are ignored.
      rx.delete();
      tx.delete();
      for (int i = 0; i < 8; i++) tx.push_back(8'(8'h30 + i));
      for (int i = 0; i < 8; i++) begin
         @(negedge mac_clk);
         in_valid = 1'b1; in_data = tx[i]; in_startofpacket = 1'b0; in_endofpacket = (i == 7); in_error = 1'b0;
      end
      idle(6);
      checks++;
      if (rx.size() != 0 || {cnt_good, cnt_fcs_err, cnt_len_err, cnt_abort} !== 64'h0) begin
         errors++;
         $display("FAIL idle_discard: got beats=%0d counters=%h %h %h %h expected 0 beats, counters 0",
                  rx.size(), cnt_good, cnt_fcs_err, cnt_len_err, cnt_abort);
      end
   endtask

   task automatic test_good();
      rx.delete();
      make_frame(60, 0);
      send_tx(-1, 0, 0, 1'b1);
      idle(6);
      exp_good++;
      checks++;
      if (rx.size() != 60) begin errors++; $display("FAIL good_beats: got %0d expected 60", rx.size()); end
      for (int i = 0; i < rx.size() && i < 60; i++) begin
         checks++;
         if ({rx[i].d, rx[i].sop, rx[i].eop} !== {8'(i), i == 0, i == 59}) begin
            errors++;
            $display("FAIL good_beat[%0d]: got d=%h sop=%b eop=%b expected d=%h sop=%b eop=%b",
                     i, rx[i].d, rx[i].sop, rx[i].eop, 8'(i), i == 0, i == 59);
         end
      end
      if (rx.size() == 60) begin
         checks++;
         if (rx[59].err !== 1'b0) begin errors++; $display("FAIL good_eop_error: got %b expected 0", rx[59].err); end
         checks++;
         if (rx[59].cyc != last_eop_cyc + 2) begin
            errors++;
            $display("FAIL good_eop_latency: got cycle %0d expected %0d", rx[59].cyc, last_eop_cyc + 2);
         end
      end
      checks++;
      if ({cnt_good, cnt_fcs_err, cnt_len_err, cnt_abort} !== {16'(exp_good), 16'(exp_fcs), 16'(exp_len), 16'(exp_abort)}) begin
         errors++;
         $display("FAIL good_counters: got %0d %0d %0d %0d expected %0d %0d %0d %0d",
                  cnt_good, cnt_fcs_err, cnt_len_err, cnt_abort, exp_good, exp_fcs, exp_len, exp_abort);
      end
   endtask

   task automatic test_fcs_err();
      rx.delete();
      make_frame(60, 0);
      tx[10] = tx[10] ^ 8'h01;
      send_tx(-1, 0, 0, 1'b1);
      idle(6);
      exp_fcs++;
      checks++;
      if (rx.size() != 60) begin errors++; $display("FAIL fcs_beats: got %0d expected 60", rx.size()); end
      for (int i = 0; i < rx.size() && i < 60; i++) begin
         checks++;
         if ({rx[i].d, rx[i].eop} !== {((i == 10) ? 8'h0B : 8'(i)), i == 59}) begin
            errors++;
            $display("FAIL fcs_beat[%0d]: got d=%h eop=%b expected d=%h eop=%b",
                     i, rx[i].d, rx[i].eop, ((i == 10) ? 8'h0B : 8'(i)), i == 59);
         end
      end
      if (rx.size() == 60) begin
         checks++;
         if (rx[59].err !== 1'b1) begin errors++; $display("FAIL fcs_eop_error: got %b expected 1", rx[59].err); end
      end
      checks++;
      if ({cnt_good, cnt_fcs_err, cnt_len_err, cnt_abort} !== {16'(exp_good), 16'(exp_fcs), 16'(exp_len), 16'(exp_abort)}) begin
         errors++;
         $display("FAIL fcs_counters: got %0d %0d %0d %0d expected %0d %0d %0d %0d",
                  cnt_good, cnt_fcs_err, cnt_len_err, cnt_abort, exp_good, exp_fcs, exp_len, exp_abort);
      end
   endtask

   task automatic test_runt();
      rx.delete();
      tx.delete();
      tx.push_back(8'hAA); tx.push_back(8'hBB); tx.push_back(8'hCC);
      send_tx(-1, 0, 0, 1'b1);
      idle(6);
      exp_len++;
      checks++;
      if (rx.size() != 0) begin errors++; $display("FAIL runt_beats: got %0d expected 0", rx.size()); end
      checks++;
      if ({cnt_good, cnt_fcs_err, cnt_len_err, cnt_abort} !== {16'(exp_good), 16'(exp_fcs), 16'(exp_len), 16'(exp_abort)}) begin
         errors++;
         $display("FAIL runt_counters: got %0d %0d %0d %0d expected %0d %0d %0d %0d",
                  cnt_good, cnt_fcs_err, cnt_len_err, cnt_abort, exp_good, exp_fcs, exp_len, exp_abort);
      end
   endtask

   task automatic test_five_byte();
      rx.delete();
      make_frame(1, 8'h5A);
      send_tx(-1, 0, 0, 1'b1);
      idle(6);
      exp_len++;
      checks++;
      if (rx.size() != 1) begin errors++; $display("FAIL five_beats: got %0d expected 1", rx.size()); end
      if (rx.size() == 1) begin
         checks++;
         if ({rx[0].d, rx[0].sop, rx[0].eop, rx[0].err} !== {8'h5A, 1'b1, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL five_beat: got d=%h sop=%b eop=%b err=%b expected d=5a sop=1 eop=1 err=1",
                     rx[0].d, rx[0].sop, rx[0].eop, rx[0].err);
         end
         checks++;
         if (rx[0].cyc != last_eop_cyc + 2) begin
            errors++;
            $display("FAIL five_latency: got cycle %0d expected %0d", rx[0].cyc, last_eop_cyc + 2);
         end
      end
      checks++;
      if ({cnt_good, cnt_fcs_err, cnt_len_err, cnt_abort} !== {16'(exp_good), 16'(exp_fcs), 16'(exp_len), 16'(exp_abort)}) begin
         errors++;
         $display("FAIL five_counters: got %0d %0d %0d %0d expected %0d %0d %0d %0d",
                  cnt_good, cnt_fcs_err, cnt_len_err, cnt_abort, exp_good, exp_fcs, exp_len, exp_abort);
      end
   endtask

   task automatic test_short();
      rx.delete();
      make_frame(16, 0);
      send_tx(-1, 0, 0, 1'b1);
      idle(6);
      exp_len++;
      checks++;
      if (rx.size() != 16) begin errors++; $display("FAIL short_beats: got %0d expected 16", rx.size()); end
      for (int i = 0; i < rx.size() && i < 16; i++) begin
         checks++;
         if ({rx[i].d, rx[i].sop, rx[i].eop} !== {8'(i), i == 0, i == 15}) begin
            errors++;
            $display("FAIL short_beat[%0d]: got d=%h sop=%b eop=%b expected d=%h sop=%b eop=%b",
                     i, rx[i].d, rx[i].sop, rx[i].eop, 8'(i), i == 0, i == 15);
         end
      end
      if (rx.size() == 16) begin
         checks++;
         if (rx[15].err !== 1'b1) begin errors++; $display("FAIL short_eop_error: got %b expected 1", rx[15].err); end
      end
      checks++;
      if ({cnt_good, cnt_fcs_err, cnt_len_err, cnt_abort} !== {16'(exp_good), 16'(exp_fcs), 16'(exp_len), 16'(exp_abort)}) begin
         errors++;
         $display("FAIL short_counters: got %0d %0d %0d %0d expected %0d %0d %0d %0d",
                  cnt_good, cnt_fcs_err, cnt_len_err, cnt_abort, exp_good, exp_fcs, exp_len, exp_abort);
      end
   endtask

   task automatic test_abort();
      rx.delete();
      tx.delete();
      for (int i = 0; i < 30; i++) tx.push_back(8'(8'h80 + i));
      send_tx(-1, 0, 0, 1'b0);
      make_frame(60, 0);
      send_tx(-1, 0, 0, 1'b1);
      idle(6);
      exp_abort++;
      exp_good++;
      // A: 25 pushes in PASS emit bytes 0..24, the new sop closes with byte 25; then B's 60 beats.
      checks++;
      if (rx.size() != 86) begin errors++; $display("FAIL abort_beats: got %0d expected 86", rx.size()); end
      for (int i = 0; i < rx.size() && i < 86; i++) begin
         checks++;
         if ({rx[i].d, rx[i].sop, rx[i].eop} !== {((i < 26) ? 8'(8'h80 + i) : 8'(i - 26)), i == 0 || i == 26, i == 25 || i == 85}) begin
            errors++;
            $display("FAIL abort_beat[%0d]: got d=%h sop=%b eop=%b expected d=%h sop=%b eop=%b",
                     i, rx[i].d, rx[i].sop, rx[i].eop, ((i < 26) ? 8'(8'h80 + i) : 8'(i - 26)),
                     i == 0 || i == 26, i == 25 || i == 85);
         end
      end
      if (rx.size() == 86) begin
         checks++;
         if ({rx[25].err, rx[85].err} !== 2'b10) begin
            errors++;
            $display("FAIL abort_eop_errors: got A=%b B=%b expected A=1 B=0", rx[25].err, rx[85].err);
         end
      end
      checks++;
      if ({cnt_good, cnt_fcs_err, cnt_len_err, cnt_abort} !== {16'(exp_good), 16'(exp_fcs), 16'(exp_len), 16'(exp_abort)}) begin
         errors++;
         $display("FAIL abort_counters: got %0d %0d %0d %0d expected %0d %0d %0d %0d",
                  cnt_good, cnt_fcs_err, cnt_len_err, cnt_abort, exp_good, exp_fcs, exp_len, exp_abort);
      end
   endtask

   task automatic test_back_to_back();
      rx.delete();
      make_frame(60, 0);
      send_tx(-1, 0, 0, 1'b1);
      make_frame(60, 8'h40);
      send_tx(-1, 0, 0, 1'b1);
      idle(6);
      exp_good += 2;
      checks++;
      if (rx.size() != 120) begin errors++; $display("FAIL b2b_beats: got %0d expected 120", rx.size()); end
      for (int i = 0; i < rx.size() && i < 120; i++) begin
         checks++;
         if ({rx[i].d, rx[i].sop, rx[i].eop, rx[i].err} !==
             {((i < 60) ? 8'(i) : 8'(8'h40 + i - 60)), i == 0 || i == 60, i == 59 || i == 119, 1'b0}) begin
            errors++;
            $display("FAIL b2b_beat[%0d]: got d=%h sop=%b eop=%b err=%b expected d=%h sop=%b eop=%b err=0",
                     i, rx[i].d, rx[i].sop, rx[i].eop, rx[i].err, ((i < 60) ? 8'(i) : 8'(8'h40 + i - 60)),
                     i == 0 || i == 60, i == 59 || i == 119);
         end
      end
      checks++;
      if ({cnt_good, cnt_fcs_err, cnt_len_err, cnt_abort} !== {16'(exp_good), 16'(exp_fcs), 16'(exp_len), 16'(exp_abort)}) begin
         errors++;
         $display("FAIL b2b_counters: got %0d %0d %0d %0d expected %0d %0d %0d %0d",
                  cnt_good, cnt_fcs_err, cnt_len_err, cnt_abort, exp_good, exp_fcs, exp_len, exp_abort);
      end
   endtask

   task automatic test_gaps_phy_err();
      rx.delete();
      make_frame(60, 0);
      send_tx(5, 8, 3, 1'b1);
      idle(6);
      exp_good++;
      checks++;
      if (rx.size() != 60) begin errors++; $display("FAIL gaps_beats: got %0d expected 60", rx.size()); end
      for (int i = 0; i < rx.size() && i < 60; i++) begin
         checks++;
         if ({rx[i].d, rx[i].sop, rx[i].eop} !== {8'(i), i == 0, i == 59}) begin
            errors++;
            $display("FAIL gaps_beat[%0d]: got d=%h sop=%b eop=%b expected d=%h sop=%b eop=%b",
                     i, rx[i].d, rx[i].sop, rx[i].eop, 8'(i), i == 0, i == 59);
         end
      end
      if (rx.size() == 60) begin
         checks++;
         if (rx[59].err !== 1'b1) begin errors++; $display("FAIL gaps_eop_error: got %b expected 1", rx[59].err); end
      end
      checks++;
      if ({cnt_good, cnt_fcs_err, cnt_len_err, cnt_abort} !== {16'(exp_good), 16'(exp_fcs), 16'(exp_len), 16'(exp_abort)}) begin
         errors++;
         $display("FAIL gaps_counters: got %0d %0d %0d %0d expected %0d %0d %0d %0d",
                  cnt_good, cnt_fcs_err, cnt_len_err, cnt_abort, exp_good, exp_fcs, exp_len, exp_abort);
      end
   endtask

   task automatic test_reset_mid_frame();
      make_frame(60, 0);
      tx = tx[0:19];
      send_tx(-1, 0, 0, 1'b0);
      @(posedge mac_clk);
      #2;
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL midrst_pre_valid: got %b expected 1", out_valid); end
      mac_rst = 1'b1;
      #1;
      checks++;
      if ({out_valid, out_startofpacket, out_endofpacket, out_data, out_error} !== 12'h0) begin
         errors++;
         $display("FAIL midrst_outputs: got v=%b sop=%b eop=%b d=%h err=%b expected all 0",
                  out_valid, out_startofpacket, out_endofpacket, out_data, out_error);
      end
      checks++;
      if ({cnt_good, cnt_fcs_err, cnt_len_err, cnt_abort} !== 64'h0) begin
         errors++;
         $display("FAIL midrst_counters: got %h %h %h %h expected 0 0 0 0", cnt_good, cnt_fcs_err, cnt_len_err, cnt_abort);
      end
      rx.delete();
      idle(2);
      mac_rst = 1'b0;
      idle(4);
      checks++;
      if (rx.size() != 0) begin errors++; $display("FAIL midrst_no_eop: got %0d beats expected 0", rx.size()); end
      exp_good = 1; exp_fcs = 0; exp_len = 0; exp_abort = 0;
      rx.delete();
      make_frame(60, 0);
      send_tx(-1, 0, 0, 1'b1);
      idle(6);
      checks++;
      if (rx.size() != 60) begin errors++; $display("FAIL midrst_next_beats: got %0d expected 60", rx.size()); end
      if (rx.size() == 60) begin
         checks++;
         if ({rx[0].d, rx[0].sop, rx[59].d, rx[59].eop, rx[59].err} !== {8'h00, 1'b1, 8'h3B, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL midrst_next_frame: got first=%h sop=%b last=%h eop=%b err=%b expected first=00 sop=1 last=3b eop=1 err=0",
                     rx[0].d, rx[0].sop, rx[59].d, rx[59].eop, rx[59].err);
         end
      end
      checks++;
      if ({cnt_good, cnt_fcs_err, cnt_len_err, cnt_abort} !== {16'(exp_good), 16'(exp_fcs), 16'(exp_len), 16'(exp_abort)}) begin
         errors++;
         $display("FAIL midrst_next_counters: got %0d %0d %0d %0d expected %0d %0d %0d %0d",
                  cnt_good, cnt_fcs_err, cnt_len_err, cnt_abort, exp_good, exp_fcs, exp_len, exp_abort);
      end
   endtask

   initial begin
      test_reset();
      test_good();
      test_fcs_err();
      test_runt();
      test_five_byte();
      test_short();
      test_abort();
      test_back_to_back();
      test_gaps_phy_err();
      test_reset_mid_frame();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
